// File: rtl/mprj_cfg_pkg.sv
// Shared definitions for the user-project pad configuration loader:
// FSM state encoding, default chain geometry and divider width.
package mprj_cfg_pkg;

  localparam int unsigned DEF_NUM_PADS = 38;
  localparam int unsigned DEF_CFG_BITS = 13;
  localparam int unsigned DIV_W        = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SHIFT_LO,
    S_SHIFT_HI,
    S_LOAD,
    S_DONE
  } state_t;

endpackage

// File: rtl/mprj_cfg_phase_ctr.sv
// Phase timer: reloads with D at the start of each phase and flags the
// phase's last clock (counter at zero), giving D+1 clocks per phase.
module mprj_cfg_phase_ctr
  import mprj_cfg_pkg::*;
(
  input  logic             clock,
  input  logic             resetb,
  input  logic             load,
  input  logic [DIV_W-1:0] load_val,
  output logic             term
);

  logic [DIV_W-1:0] cnt_q;

  // Saturates at zero between phases so it never wraps.
  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - DIV_W'(1);
    end
  end

  assign term = (cnt_q == '0);

endmodule

// File: rtl/mprj_cfg_loader.sv
// Serial pad-configuration loader: shifts a snapshotted image out MSB-first,
// pad NUM_PADS-1 first, then strobes serial_load. Optional readback capture
// is enabled by defining MPRJ_CFG_READBACK_EN.
module mprj_cfg_loader
  import mprj_cfg_pkg::*;
#(
  parameter int unsigned NUM_PADS = DEF_NUM_PADS,
  parameter int unsigned CFG_BITS = DEF_CFG_BITS
) (
  input  logic                         clock,
  input  logic                         resetb,
  input  logic                         start,
  input  logic [NUM_PADS*CFG_BITS-1:0] cfg_data,
  input  logic [DIV_W-1:0]             clk_div,
  output logic                         busy,
  output logic                         done,
  output logic                         serial_clock,
  output logic                         serial_data,
  output logic                         serial_load
`ifdef MPRJ_CFG_READBACK_EN
  ,
  input  logic                         serial_data_in,
  output logic [NUM_PADS*CFG_BITS-1:0] rb_data,
  output logic                         rb_valid
`endif
);

  localparam int unsigned TB = NUM_PADS * CFG_BITS;
  localparam int unsigned BW = (TB > 1) ? $clog2(TB) : 1;

  state_t          state_q, state_d;
  logic [TB-1:0]   snap_q;
  logic [DIV_W-1:0] div_q;
  logic [BW-1:0]   bit_cnt_q;
  logic            term;
  logic            ctr_load;
  logic [DIV_W-1:0] ctr_val;
  logic            last_bit;
  logic            accept;

  assign accept   = (state_q == S_IDLE) && start;
  assign last_bit = (bit_cnt_q == BW'(TB - 1));

  // The first phase must load clk_div directly: the snapshot is not yet valid.
  mprj_cfg_phase_ctr u_phase_ctr (
    .clock    (clock),
    .resetb   (resetb),
    .load     (ctr_load),
    .load_val (ctr_val),
    .term     (term)
  );

  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    ctr_load = 1'b0;
    ctr_val  = div_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d  = S_SHIFT_LO;
          ctr_load = 1'b1;
          ctr_val  = clk_div;
        end
      end
      S_SHIFT_LO: begin
        if (term) begin
          state_d  = S_SHIFT_HI;
          ctr_load = 1'b1;
        end
      end
      S_SHIFT_HI: begin
        if (term) begin
          state_d  = last_bit ? S_LOAD : S_SHIFT_LO;
          ctr_load = 1'b1;
        end
      end
      S_LOAD: begin
        if (term) begin
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Snapshot doubles as the output shift register: its MSB is the current bit.
  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      snap_q    <= '0;
      div_q     <= '0;
      bit_cnt_q <= '0;
    end else if (accept) begin
      snap_q    <= cfg_data;
      div_q     <= clk_div;
      bit_cnt_q <= '0;
    end else if ((state_q == S_SHIFT_HI) && term) begin
      snap_q <= snap_q << 1;
      if (!last_bit) begin
        bit_cnt_q <= bit_cnt_q + BW'(1);
      end
    end
  end

  assign busy         = (state_q == S_SHIFT_LO) || (state_q == S_SHIFT_HI) ||
                        (state_q == S_LOAD);
  assign done         = (state_q == S_DONE);
  assign serial_clock = (state_q == S_SHIFT_HI);
  assign serial_load  = (state_q == S_LOAD);
  assign serial_data  = snap_q[TB-1];

`ifdef MPRJ_CFG_READBACK_EN
  logic [TB-1:0] rb_q;

  // Sampled on the last LO clock, before the chain shifts on the HI edge.
  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      rb_q <= '0;
    end else if (accept) begin
      rb_q <= '0;
    end else if ((state_q == S_SHIFT_LO) && term) begin
      rb_q <= (rb_q << 1) | TB'(serial_data_in);
    end
  end

  assign rb_data  = rb_q;
  assign rb_valid = (state_q == S_DONE);
`endif

endmodule

// File: tb/tb_mprj_cfg_loader.sv
// Bench for mprj_cfg_loader (2 pads x 3 bits): waveform model plus directed
// literal checks; readback checks are added when MPRJ_CFG_READBACK_EN is set.
module tb_mprj_cfg_loader;

  localparam int NP = 2;
  localparam int CB = 3;
  localparam int TB = NP * CB;

  logic          clock = 1'b0;
  logic          resetb = 1'b0;
  logic          start = 1'b0;
  logic [TB-1:0] cfg_data = '0;
  logic [7:0]    clk_div = '0;
  logic          busy, done, serial_clock, serial_data, serial_load;
`ifdef MPRJ_CFG_READBACK_EN
  logic          serial_data_in;
  logic [TB-1:0] rb_data;
  logic          rb_valid;
  logic [TB-1:0] chain = '0;
  logic          rb_preload = 1'b0;
  logic          sc_prev = 1'b0;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  mprj_cfg_loader #(.NUM_PADS(NP), .CFG_BITS(CB)) dut (
    .clock        (clock),
    .resetb       (resetb),
    .start        (start),
    .cfg_data     (cfg_data),
    .clk_div      (clk_div),
    .busy         (busy),
    .done         (done),
    .serial_clock (serial_clock),
    .serial_data  (serial_data),
    .serial_load  (serial_load)
`ifdef MPRJ_CFG_READBACK_EN
    ,
    .serial_data_in (serial_data_in),
    .rb_data        (rb_data),
    .rb_valid       (rb_valid)
`endif
  );

  always #5 clock = ~clock;

`ifdef MPRJ_CFG_READBACK_EN
  // External chain model: shifts serial_data in on each serial_clock rise.
  assign serial_data_in = chain[TB-1];
  always @(posedge clock) begin
    if (rb_preload) chain <= 6'b110_001;
    else if (serial_clock && !sc_prev) chain <= {chain[TB-2:0], serial_data};
    sc_prev <= serial_clock;
  end
`endif

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected per-cycle outputs of one load, built from the shift-order rules.
  typedef struct packed {
    logic busy;
    logic done;
    logic sclk;
    logic sdata;
    logic sload;
    logic chk_sd;
  } exp_t;

  localparam exp_t IDLE_E = '{busy: 1'b0, done: 1'b0, sclk: 1'b0, sdata: 1'b0, sload: 1'b0, chk_sd: 1'b0};

  exp_t q[$];
  exp_t cur = IDLE_E;

  function automatic void build(input logic [TB-1:0] data, input logic [7:0] d);
    exp_t e;
    for (int p = NP - 1; p >= 0; p--) begin
      for (int b = CB - 1; b >= 0; b--) begin
        e = '{busy: 1'b1, done: 1'b0, sclk: 1'b0, sdata: data[p*CB+b], sload: 1'b0, chk_sd: 1'b1};
        for (int i = 0; i <= int'(d); i++) q.push_back(e);
        e.sclk = 1'b1;
        for (int i = 0; i <= int'(d); i++) q.push_back(e);
      end
    end
    e = '{busy: 1'b1, done: 1'b0, sclk: 1'b0, sdata: 1'b0, sload: 1'b1, chk_sd: 1'b0};
    for (int i = 0; i <= int'(d); i++) q.push_back(e);
    e = '{busy: 1'b0, done: 1'b1, sclk: 1'b0, sdata: 1'b0, sload: 1'b0, chk_sd: 1'b0};
    q.push_back(e);
  endfunction

  always @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      q.delete();
      cur = IDLE_E;
    end else begin
      if (q.size() == 0 && !cur.busy && !cur.done && start) build(cfg_data, clk_div);
      cur = (q.size() > 0) ? q.pop_front() : IDLE_E;
    end
  end

  always @(negedge clock) begin
    check("busy", busy, cur.busy);
    check("done", done, cur.done);
    check("serial_clock", serial_clock, cur.sclk);
    check("serial_load", serial_load, cur.sload);
    if (cur.chk_sd) check("serial_data", serial_data, cur.sdata);
    else if (!resetb) check("serial_data_rst", serial_data, 1'b0);
`ifdef MPRJ_CFG_READBACK_EN
    check("rb_valid", rb_valid, cur.done);
    if (!resetb) check("rb_data_rst", rb_data, '0);
`endif
  end

  task automatic wait_idle();
    int n;
    n = 0;
    while ((busy || done) && n < 10000) begin
      @(negedge clock);
      n++;
    end
    if (busy || done) check("idle_timeout", 1'b0, 1'b1);
    @(negedge clock);
  endtask

  // Runs one load (inputs scrambled while busy) and measures it in cycles
  // counted from the edge that sampled start.
  task automatic directed(input logic [TB-1:0] data, input logic [7:0] d,
                          input int poke_cyc, input bit poke_done,
                          output int done_cyc, output int load_cyc,
                          output int highs, output logic [TB-1:0] bits);
    int cyc;
    logic prev_sc;
    done_cyc = -1; load_cyc = 0; highs = 0; bits = '0; prev_sc = 1'b0;
    @(negedge clock);
    start = 1'b1; cfg_data = data; clk_div = d;
    @(negedge clock);
    start = 1'b0;
    for (cyc = 1; cyc <= 5000; cyc++) begin
      if (serial_clock && !prev_sc) begin
        highs++;
        bits = {bits[TB-2:0], serial_data};
      end
      prev_sc = serial_clock;
      if (serial_load && load_cyc == 0) load_cyc = cyc;
      if (done) begin
        done_cyc = cyc;
        start = poke_done;
        break;
      end
      cfg_data = TB'($urandom);
      clk_div  = 8'($urandom);
      start    = (cyc == poke_cyc);
      @(negedge clock);
    end
  endtask

  initial begin
    int dc, lc, hi, cnt_b, cnt_d, cnt_l, n;
    logic [TB-1:0] bits;

    repeat (3) @(negedge clock);
    check("rst_busy", busy, 1'b0);
    check("rst_outputs", {done, serial_clock, serial_data, serial_load}, 4'b0000);
    resetb = 1'b1;
    repeat (2) @(negedge clock);

    directed(6'b101_011, 8'd0, 0, 1'b0, dc, lc, hi, bits);
    check("d0_done_cycle", dc, 14);
    check("d0_load_cycle", lc, 13);
    check("d0_clock_highs", hi, 6);
    check("d0_bit_sequence", bits, 6'b101_011);
    wait_idle();

    directed(6'b101_011, 8'd3, 0, 1'b0, dc, lc, hi, bits);
    check("d3_done_cycle", dc, 53);
    check("d3_load_cycle", lc, 49);
    check("d3_bit_sequence", bits, 6'b101_011);
    wait_idle();

    // Start pokes at cycle 5 and in the DONE cycle must both be ignored.
    directed(6'b011_110, 8'd0, 5, 1'b1, dc, lc, hi, bits);
    check("poke_done_cycle", dc, 14);
    check("poke_bit_sequence", bits, 6'b011_110);
    @(negedge clock);
    start = 1'b0;
    cnt_b = 0; cnt_d = 0;
    repeat (40) begin
      @(negedge clock);
      cnt_b += int'(busy);
      cnt_d += int'(done);
    end
    check("poke_no_reload", cnt_b + cnt_d, 0);

    // Reset asserted in the middle of a SHIFT_HI phase.
    @(negedge clock);
    start = 1'b1; cfg_data = 6'b111_111; clk_div = 8'd2;
    @(negedge clock);
    start = 1'b0;
    n = 0;
    while (!serial_clock && n < 200) begin
      @(negedge clock);
      n++;
    end
    check("reach_shift_hi", serial_clock, 1'b1);
    #2 resetb = 1'b0;
    #1;
    check("abort_busy", busy, 1'b0);
    check("abort_outputs", {done, serial_clock, serial_data, serial_load}, 4'b0000);
    @(negedge clock);
    @(negedge clock);
    resetb = 1'b1;
    cnt_d = 0; cnt_l = 0;
    repeat (60) begin
      @(negedge clock);
      cnt_d += int'(done);
      cnt_l += int'(serial_load);
    end
    check("abort_no_load_done", cnt_d + cnt_l, 0);
    directed(6'b100_101, 8'd0, 0, 1'b0, dc, lc, hi, bits);
    check("post_abort_done", dc, 14);
    check("post_abort_bits", bits, 6'b100_101);
    wait_idle();

`ifdef MPRJ_CFG_READBACK_EN
    @(negedge clock);
    rb_preload = 1'b1;
    @(negedge clock);
    rb_preload = 1'b0;
    directed(6'b010_011, 8'd1, 0, 1'b0, dc, lc, hi, bits);
    check("rb_done_cycle", dc, 2 * 2 * TB + 2 + 1);
    check("rb_valid_pulse", rb_valid, 1'b1);
    check("rb_data", rb_data, 6'b110_001);
    wait_idle();
`endif

    // Random traffic: random starts, data and divider every cycle.
    repeat (2500) begin
      @(negedge clock);
      start    = ($urandom_range(0, 3) == 0);
      cfg_data = TB'($urandom);
      clk_div  = 8'($urandom_range(0, 3));
    end
    start = 1'b0;
    wait_idle();

    directed(6'b110_100, 8'd255, 0, 1'b0, dc, lc, hi, bits);
    check("d255_done_cycle", dc, 2 * 256 * TB + 256 + 1);
    check("d255_bit_sequence", bits, 6'b110_100);
    wait_idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mprj_cfg_loader.md
MPRJ_CFG_LOADER -- requirements
Module: mprj_cfg_loader

Interface
REQ-001 Parameter NUM_PADS, default 38: number of user pads in the serial configuration chain; legal range 1..64.
REQ-002 Parameter CFG_BITS, default 13: configuration bits per pad; legal range 1..32.
REQ-003 Derived constant TB = NUM_PADS*CFG_BITS: total chain length in bits.
REQ-004 Port clock, input, 1: the single clock; all logic is on its rising edge.
REQ-005 Port resetb, input, 1: reset, asynchronous assert, active-low.
REQ-006 Port start, input, 1: load request, sampled each clock.
REQ-007 Port cfg_data, input, TB: configuration image; pad p occupies bits [p*CFG_BITS +: CFG_BITS].
REQ-008 Port clk_div, input, 8: divider value D; each serial phase lasts D+1 clocks.
REQ-009 Port busy, output, 1: high while a load is in progress.
REQ-010 Port done, output, 1: one-cycle pulse when a load completes.
REQ-011 Port serial_clock, output, 1: chain shift clock.
REQ-012 Port serial_data, output, 1: chain data.
REQ-013 Port serial_load, output, 1: chain latch strobe.

Function
REQ-014 States are IDLE, SHIFT_LO, SHIFT_HI, LOAD and DONE.
REQ-015 In IDLE, start=1 snapshots cfg_data and clk_div, then enters SHIFT_LO with the bit counter at 0.
REQ-016 start while busy=1 or in DONE is ignored; cfg_data and clk_div changes during a load have no effect.
REQ-017 Shift order: pad NUM_PADS-1 first, pad 0 last; MSB first within each pad; bit k drives serial_data for the whole of its LO and HI phases.
REQ-018 SHIFT_LO: serial_clock=0 for D+1 cycles, then SHIFT_HI.
REQ-019 SHIFT_HI: serial_clock=1 for D+1 cycles, then the bit counter increments; go to SHIFT_LO if more bits remain, otherwise LOAD.
REQ-020 LOAD: serial_load=1 and serial_clock=0 for D+1 cycles, then DONE.
REQ-021 DONE: done=1 and busy=0 for exactly one cycle, then IDLE; a start arriving in DONE is ignored.
REQ-022 busy=1 in SHIFT_LO, SHIFT_HI and LOAD only.
REQ-023 Latency: done is high in the cycle 2*(D+1)*TB+(D+1)+1 clocks after the edge that samples start.
REQ-024 D=0 is legal (one clock per phase); D=255 gives 256 clocks per phase; the phase counter never wraps mid-phase.
REQ-025 The bit counter is sized for TB; the terminal count is TB-1, with no wrap past it.

Reset
REQ-026 While resetb=0 the state is IDLE and busy, done, serial_clock, serial_data and serial_load are all 0; all counters and snapshots are cleared.
REQ-027 resetb asserted mid-load aborts immediately: no serial_load pulse and no done pulse are produced; after release the block waits for a new start.

Configuration
REQ-028 Macro MPRJ_CFG_READBACK_EN, when defined, adds input serial_data_in (1 bit) and outputs rb_data (TB bits) and rb_valid (1 bit).
REQ-029 With the macro defined, serial_data_in is sampled on the last clock of each SHIFT_LO phase and shifted into rb_data, so the first sampled bit ends in rb_data[TB-1].
REQ-030 With the macro defined, rb_valid pulses together with done; rb_data holds its value until the next load starts; rb_data and rb_valid reset to 0.
REQ-031 Without the macro, none of serial_data_in, rb_data or rb_valid exist, and no readback logic is present.

Structure
REQ-032 Package mprj_cfg_pkg holds the state encoding, the default NUM_PADS and CFG_BITS, and the clk_div width constant.
REQ-033 The phase timer is the sub-module mprj_cfg_phase_ctr: it loads D at the start of each phase and raises a terminal flag when the phase ends.

Verification
REQ-034 NUM_PADS=2, CFG_BITS=3, D=0, cfg_data=6'b101_011: serial_data sequence is 1,0,1,0,1,1; there are 6 serial_clock highs; serial_load=1 at cycle 13; done=1 at cycle 14.
REQ-035 Same configuration with D=3: every phase lasts 4 clocks; done=1 at cycle 53.
REQ-036 start pulsed at cycle 5 of a load and again in the DONE cycle: both are ignored, exactly one done is produced, and no second load starts.
REQ-037 resetb pulsed low in the middle of SHIFT_HI: all outputs are 0 at once; no serial_load or done pulse follows; a new start then completes a normal load.
REQ-038 cfg_data changed every cycle during a load: the shifted bits match the snapshot taken at start.
REQ-039 With MPRJ_CFG_READBACK_EN and serial_data_in looped through a TB-bit model chain preloaded with 6'b110_001: rb_data=6'b110_001 when rb_valid pulses.
